// File: rtl/asymmetric_fifo_n2w.sv
// Narrow-to-wide FWFT FIFO: packs RATIO bytes per wide word, first byte in the LSB lane.
// Optional sticky error flag for illegal push/pop enabled by ASYMMETRIC_FIFO_N2W_ERR_EN.
module asymmetric_fifo_n2w #(
  parameter int NW        = 8,
  parameter int RATIO     = 8,
  parameter int DEPTH     = 8,
  parameter int CW        = 8,
  parameter int AF_MARGIN = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [NW-1:0]       d,
  output logic [NW*RATIO-1:0] q,
  output logic                full,
  output logic                empty,
  output logic [CW-1:0]       count,
  output logic                almost_empty,
  output logic                almost_full
`ifdef ASYMMETRIC_FIFO_N2W_ERR_EN
  ,
  output logic                err
`endif
);

  localparam int CAP = DEPTH * RATIO;
  localparam int AW  = $clog2(CAP);
  localparam int RW  = $clog2(DEPTH);

  logic [NW-1:0] mem [CAP];
  logic [AW-1:0] wp;
  logic [RW-1:0] rp;
  logic          push_ok;
  logic          pop_ok;

  assign full         = (count == CW'(CAP));
  assign empty        = (count <  CW'(RATIO));
  assign almost_empty = (count <  CW'(2 * RATIO));
  assign almost_full  = (count >= CW'(CAP - AF_MARGIN));

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // The oldest word is read straight out of storage so q is valid as soon as empty drops.
  always_comb begin
    q = '0;
    for (int i = 0; i < RATIO; i++) begin
      q[i*NW +: NW] = mem[AW'(rp) * AW'(RATIO) + AW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wp] <= d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop_ok)  rp <= rp + 1'b1;
      count <= count + CW'(push_ok) - (pop_ok ? CW'(RATIO) : CW'(0));
    end
  end

`ifdef ASYMMETRIC_FIFO_N2W_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((push && full) || (pop && empty)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule
